// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder built around one full_adder cell.
// Operands are shifted out LSB first, one bit per clock. The carry is held
// in a flip-flop between bit slices. The result is published with a
// one-cycle done pulse.
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input, which selects
// op_a - op_b (two's complement: ~op_b with a carry-in of 1).

module full_adder (
  input  logic a,
  input  logic b,
  input  logic Cin,
  output logic s,
  output logic Cout
);
  assign s    = a ^ b ^ Cin;
  assign Cout = (a & b) | (Cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry_q;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_s;
  logic             w_fa_cout;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

  // The single bit-slice adder; it always looks at the LSBs and the held carry.
  full_adder u_fa (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .Cin  (r_carry_q),
    .s    (w_s),
    .Cout (w_fa_cout)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; start is honoured only in IDLE.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_SHIFT;
          w_accept     = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_SHIFT;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand B / carry-in selection at capture time (subtract inverts B, forces carry).
  always_comb begin
    w_b_load = op_b;
    w_c_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      w_b_load = ~op_b;
      w_c_load = 1'b1;
    end else begin
      w_b_load = op_b;
      w_c_load = cin;
    end
`endif
  end

  // Result shift register after this slice: the new sum bit enters at the MSB.
  always_comb begin
    w_res_next            = r_res_sr >> 1;
    w_res_next[WIDTH-1]   = w_s;
  end

  // Datapath: capture operands on accept, then shift one bit per SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr    <= {WIDTH{1'b0}};
      r_b_sr    <= {WIDTH{1'b0}};
      r_res_sr  <= {WIDTH{1'b0}};
      r_carry_q <= 1'b0;
      r_cnt     <= {CW{1'b0}};
    end else if (w_accept) begin
      r_a_sr    <= op_a;
      r_b_sr    <= w_b_load;
      r_res_sr  <= {WIDTH{1'b0}};
      r_carry_q <= w_c_load;
      r_cnt     <= {CW{1'b0}};
    end else if (r_state == S_SHIFT) begin
      r_a_sr    <= r_a_sr >> 1;
      r_b_sr    <= r_b_sr >> 1;
      r_res_sr  <= w_res_next;
      r_carry_q <= w_fa_cout;
      r_cnt     <= r_cnt + CW'(1);
    end else begin
      r_a_sr    <= r_a_sr;
      r_b_sr    <= r_b_sr;
      r_res_sr  <= r_res_sr;
      r_carry_q <= r_carry_q;
      r_cnt     <= r_cnt;
    end
  end

  // Registered handshake and result; sum/cout change only on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_sum  <= {WIDTH{1'b0}};
      r_cout <= 1'b0;
    end else begin
      r_busy <= (w_next_state == S_SHIFT);
      r_done <= (w_next_state == S_DONE);
      if ((r_state == S_SHIFT) && w_last) begin
        r_sum  <= w_res_next;
        r_cout <= w_fa_cout;
      end else begin
        r_sum  <= r_sum;
        r_cout <= r_cout;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller that sequences a single full_adder cell over a WIDTH-bit operand pair, one bit per clock, LSB first. It holds the operands in shift registers and keeps the carry in a flip-flop between bit slices. A start/busy/done handshake makes it a low-area alternative to a ripple adder wherever multi-cycle latency is acceptable.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1 to 32).

Ports:
clk  input  1  rising-edge clock; the only clock in the block.
rst_n  input  1  reset, asynchronous, active-low.
start  input  1  request; sampled only in IDLE.
op_a  input  WIDTH  operand A; captured when start is accepted.
op_b  input  WIDTH  operand B; captured when start is accepted.
cin  input  1  carry-in; captured when start is accepted.
busy  output  1  high while in SHIFT.
done  output  1  one-cycle pulse when the result is valid.
sum  output  WIDTH  registered result; held until the next completion.
cout  output  1  registered final carry; held until the next completion.

Behaviour:
- Interface: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Datapath: exactly one full_adder instance, with ports a, b, Cin, s and Cout.
  - a is driven by a_sr[0], b by b_sr[0], Cin by carry_q.
- Reset (rst_n=0, takes effect immediately, no clock needed):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry_q and bit counter all cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge E0:
  - a_sr<=op_a, b_sr<=op_b, carry_q<=cin, cnt<=0.
  - Next state SHIFT.
- IDLE, start=0: remain in IDLE.
- SHIFT, at each edge E1 to EWIDTH:
  - a_sr and b_sr shift right by 1.
  - res_sr shifts right, with the full_adder s output entering at bit WIDTH-1.
  - carry_q<=Cout, cnt<=cnt+1.
- SHIFT, at the edge where cnt==WIDTH-1 (edge EWIDTH):
  - sum<=final res_sr value, including the last s bit; cout<=Cout.
  - Next state DONE.
- DONE: done=1 for exactly one cycle, then unconditionally to IDLE.
- Latency:
  - done is high in the cycle after edge EWIDTH, i.e. WIDTH+1 edges after start is sampled.
  - The next start can be accepted at edge EWIDTH+2 at the earliest.
- busy is high after E0 through edge EWIDTH, and low in IDLE and DONE.
- start while in SHIFT or DONE is ignored. There is no queueing, and captured operands are unaffected.
- op_a, op_b and cin are don't-care except at the accepting edge.
- sum and cout keep the previous result throughout SHIFT. They change only at the transition into DONE.
- Arithmetic: {cout,sum} = op_a + op_b + cin, modulo 2^(WIDTH+1); there is no overflow flag.
- Counter width is clog2(WIDTH+1). WIDTH=1 gives a single SHIFT cycle.
- Reset asserted mid-SHIFT aborts the operation: no done pulse, and sum/cout are cleared to 0.

Optional Feature:
SERIAL_ADDER_SUB_EN
- Defined:
  - Adds input port sub (1 bit), sampled together with start.
  - When sub=1: b_sr captures ~op_b and carry_q captures 1, so cin is ignored. Result is op_a - op_b.
  - In subtract mode, cout=1 means no borrow (op_a >= op_b, unsigned).
  - When sub=0: behaviour is identical to the undefined case.
- Undefined:
  - No sub port exists; the block performs addition only.
  - Timing is identical in both builds.

Test Plan:
- WIDTH=8, op_a=0x5A, op_b=0x3C, cin=0, start pulsed 1 cycle
  -> busy high for 8 cycles; done pulses 9 edges after start; sum=0x96, cout=0.
- op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1.
- op_a=0xFF, op_b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start 0x12+0x34, then pulse start with 0xAA+0x55 during SHIFT
  -> second request ignored; sum=0x46, cout=0; exactly one done pulse.
- Start 0x80+0x80; drop rst_n at the 4th SHIFT cycle
  -> outputs go to 0 immediately, no done pulse.
  -> Then 0x01+0x01 after release gives sum=0x02.
- SERIAL_ADDER_SUB_EN defined:
  - sub=1, 0x10-0x01 -> sum=0x0F, cout=1.
  - sub=1, 0x01-0x02 -> sum=0xFF, cout=0.
  - sub=0, 0x10+0x01 -> sum=0x11, cout=0.
